// File: rtl/uart_fifo_bridge_if.sv
// CPU register bus and UART register port of the bridge, bundled in one interface.
// slave = bridge view, master = CPU/UART environment view.
interface uart_fifo_bridge_if;
  logic        we_i;
  logic        re_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        irq_o;
  logic        u_we_o;
  logic [31:0] u_addr_o;
  logic [31:0] u_data_o;
  logic [31:0] u_data_i;

  modport slave (
    input  we_i, re_i, addr_i, data_i, u_data_i,
    output data_o, irq_o, u_we_o, u_addr_o, u_data_o
  );

  modport master (
    output we_i, re_i, addr_i, data_i, u_data_i,
    input  data_o, irq_o, u_we_o, u_addr_o, u_data_o
  );
endinterface

// File: rtl/uart_fifo_bridge.sv
// Byte FIFO: push/pop land on the next edge; a full FIFO accepts a push only alongside a pop.
// push_ok_o tells the producer whether its push was taken.
module uart_fifo_bridge_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [7:0]    din_i,
  output logic [7:0]    dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          push_ok_o
);
  localparam int PW = CW - 1;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  assign push_ok_o = do_push;
  assign dout_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// CPU-side TX/RX FIFOs plus a master FSM polling the UART register port.
// TXDATA write reaches the UART 2 cycles later; FIFOs full -> bytes dropped, sticky ovf flags.
module uart_fifo_bridge #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input logic              clk,
  input logic              rst,
  uart_fifo_bridge_if.slave bus
);
  localparam logic [31:0] UA_STAT = 32'h04;
  localparam logic [31:0] UA_TX   = 32'h0C;
  localparam logic [31:0] UA_RX   = 32'h10;

  typedef enum logic [2:0] {
    IDLE,
    RD_RX,
    CLR_RX,
    WR_TX,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic          tx_ovf_q, tx_ovf_d;
  logic          rx_ovf_q, rx_ovf_d;

  logic [3:0]    cpu_addr;
  logic          cpu_tx_push, cpu_clr, cpu_rx_pop;
  logic          fsm_tx_pop, fsm_rx_push;
  logic          u_we;
  logic [31:0]   u_addr, u_wdat;

  logic [7:0]    tx_head, rx_head;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_full, tx_empty, tx_push_ok;
  logic          rx_full, rx_empty, rx_push_ok;
  logic [31:0]   status, rd_data;
  logic          unused_bits;

  assign cpu_addr    = bus.addr_i[3:0];
  assign cpu_tx_push = bus.we_i && (cpu_addr == 4'h0);
  assign cpu_clr     = bus.we_i && (cpu_addr == 4'hC);
  assign cpu_rx_pop  = bus.re_i && (cpu_addr == 4'h4);
  assign unused_bits = ^{bus.addr_i[31:4], bus.data_i[31:8], bus.u_data_i[31:8],
                         rx_full, tx_count[0]};

  uart_fifo_bridge_fifo #(.DEPTH(DEPTH), .CW(CW)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (cpu_tx_push),
    .pop_i     (fsm_tx_pop),
    .din_i     (bus.data_i[7:0]),
    .dout_o    (tx_head),
    .count_o   (tx_count),
    .full_o    (tx_full),
    .empty_o   (tx_empty),
    .push_ok_o (tx_push_ok)
  );

  uart_fifo_bridge_fifo #(.DEPTH(DEPTH), .CW(CW)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (fsm_rx_push),
    .pop_i     (cpu_rx_pop),
    .din_i     (bus.u_data_i[7:0]),
    .dout_o    (rx_head),
    .count_o   (rx_count),
    .full_o    (rx_full),
    .empty_o   (rx_empty),
    .push_ok_o (rx_push_ok)
  );

  // Every write state is followed by a non-write state, so u_we never holds two cycles.
  always_comb begin
    state_d     = state_q;
    u_we        = 1'b0;
    u_addr      = UA_STAT;
    u_wdat      = 32'h0;
    fsm_tx_pop  = 1'b0;
    fsm_rx_push = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.u_data_i[1]) begin
          state_d = RD_RX;
        end else if (!bus.u_data_i[0] && !tx_empty) begin
          state_d = WR_TX;
        end
      end
      RD_RX: begin
        u_addr      = UA_RX;
        fsm_rx_push = 1'b1;
        state_d     = CLR_RX;
      end
      CLR_RX: begin
        u_we    = 1'b1;
        state_d = GAP;
      end
      WR_TX: begin
        u_we       = 1'b1;
        u_addr     = UA_TX;
        u_wdat     = {24'h0, tx_head};
        fsm_tx_pop = 1'b1;
        state_d    = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Set is applied after clear so a coincident overflow keeps the flag.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_ovf_d = rx_ovf_q;
    if (cpu_clr && bus.data_i[1]) tx_ovf_d = 1'b0;
    if (cpu_clr && bus.data_i[0]) rx_ovf_d = 1'b0;
    if (cpu_tx_push && !tx_push_ok) tx_ovf_d = 1'b1;
    if (fsm_rx_push && !rx_push_ok) rx_ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
    end
  end

  always_comb begin
    status           = 32'h0;
    status[CW-1:0]   = tx_count;
    status[CW+7:8]   = rx_count;
    status[16]       = tx_full;
    status[17]       = rx_empty;
    status[18]       = rx_ovf_q;
    status[19]       = tx_ovf_q;
    case (cpu_addr)
      4'h4:    rd_data = rx_empty ? 32'h0 : {24'h0, rx_head};
      4'h8:    rd_data = status;
      default: rd_data = 32'h0;
    endcase
  end

  assign bus.data_o   = rd_data;
  assign bus.irq_o    = !rx_empty;
  assign bus.u_we_o   = u_we;
  assign bus.u_addr_o = u_addr;
  assign bus.u_data_o = u_wdat;
endmodule
